sqrt_arbiter: RTL and testbench
===============================

# sqrt_arbiter

Round-robin scheduler that shares one iterative 16-bit square-root unit (`start`/`in` → `out`/`error`/`done`) among `NREQ` requesters. It sits between the requester ports and the sqrt datapath. It accepts one operand at a time, issues a single start pulse, and waits for completion or a timeout. It then returns the 8-bit root plus status, tagged with the requester index, over a valid/ready response port.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 32: maximum WAIT cycles before a forced timeout response (≥ 16).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset. Low clears all state immediately.
- `req_valid` input NREQ: per-requester request valid. Held until accepted.
- `req_data` input NREQ*16: operands. Requester i occupies bits [16i+15:16i].
- `req_ready` output NREQ: one-hot accept strobe. A handshake occurs when `req_valid[i]` and `req_ready[i]` are both high.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: response consumer ready.
- `rsp_id` output clog2(NREQ) (min 1): index of the requester being answered.
- `rsp_root` output 8: square root result. Zero on error or timeout.
- `rsp_error` output 1: negative operand (`in[15]`=1) or timeout.
- `rsp_timeout` output 1: no `sq_done` within `TIMEOUT` cycles.
- `sq_start` output 1: start pulse to the sqrt unit.
- `sq_in` output 16: operand to the sqrt unit.
- `sq_out` input 8: root from the sqrt unit.
- `sq_error` input 1: negative-input flag from the sqrt unit.
- `sq_done` input 1: completion level from the sqrt unit.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is high, grant the first valid index searching upward from `last+1` (mod NREQ).
  - Drive `req_ready` high for the granted index only, combinationally, in this cycle.
  - Latch operand and id, then go to ISSUE.
  - With no requests, stay in IDLE with `req_ready`=0.
- **ISSUE**
  - `sq_start`=1 for exactly this one cycle. `sq_in` holds the latched operand.
  - Clear the timer. Go to WAIT.
- **WAIT**
  - `sq_done` is sampled only in this state. The sqrt unit clears or refreshes `done` on the start edge, so a stale `done` cannot be seen here.
  - On `sq_done`=1: capture `rsp_root` = `sq_error` ? 0 : `sq_out`, `rsp_error` = `sq_error`, `rsp_timeout` = 0. Go to RESP.
  - Otherwise increment the timer. When the timer reaches `TIMEOUT`-1 without `sq_done`: capture root 0, `rsp_error` = 1, `rsp_timeout` = 1. Go to RESP.
- **RESP**
  - `rsp_valid` = 1. All rsp fields stay stable until the handshake.
  - On `rsp_ready`: set `last` = granted id, go to IDLE.
  - A new request cannot be accepted in this same cycle, so there is one idle bubble.
- `sq_in` holds the last latched operand outside ISSUE. The sqrt unit only samples it on `start`.
- At most one operation is in flight. `req_ready` is 0 in every state except IDLE.
- Reset values:
  - All outputs 0.
  - `last` = NREQ-1, so requester 0 has first priority after reset.
  - Timer 0; operand and id latches 0.
- Reset asserted mid-operation aborts everything and drops any pending response. The sqrt unit is reset by the same signal.

## Timing
- Handshake in IDLE at cycle t gives:
  - `sq_start` high in cycle t+1;
  - WAIT from t+2;
  - `rsp_valid` at d+1, where d is the first WAIT cycle with `sq_done`=1.
- Negative operand: `sq_done` is visible at t+2, so `rsp_valid` rises at t+3.
- Nominal Newton path: `sq_done` around t+13, `rsp_valid` around t+14.
- Timeout: `rsp_valid` rises in cycle t+2+`TIMEOUT`.
- Minimum spacing between successive accepts is 4 cycles (IDLE, ISSUE, WAIT, RESP with `rsp_ready` held high).
- Round-robin pointer:
  - Updated only on response handshake.
  - Wraps from NREQ-1 to 0.
  - Simultaneous requests are served in rotating order. No requester waits more than NREQ-1 operations.

## Test plan
- Single request, id 2, operand 16'd144, `rsp_ready`=1 → `sq_start` pulses once. Response: `rsp_id`=2, root 12, error 0, timeout 0.
- Negative operand 16'h8001 from id 0 → `rsp_valid` 3 cycles after accept. Response: `rsp_error`=1, `rsp_timeout`=0, root 0.
- All 4 requesters valid continuously after reset, operands 0, 1, 4, 9 → served in order 0, 1, 2, 3, then 0 again. Roots 0, 1, 2, 3.
- Stub the sqrt unit so `sq_done` never rises, `TIMEOUT`=32 → response exactly 34 cycles after accept. Response: `rsp_error`=1, `rsp_timeout`=1. FSM returns to IDLE after the handshake.
- Hold `rsp_ready`=0 for 20 cycles with another request pending → rsp fields stable, `req_ready` stays 0, no `sq_start`. The next accept occurs one cycle after `rsp_ready` goes high.
- Drive `rst` low during WAIT → all outputs 0 immediately. After release, requester 0 wins arbitration first.

Source files
------------

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin scheduler sharing one iterative 16-bit sqrt unit among NREQ requesters
module sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 32,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*16-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [7:0]           rsp_root,
    output logic                 rsp_error,
    output logic                 rsp_timeout,
    output logic                 sq_start,
    output logic [15:0]          sq_in,
    input  logic [7:0]           sq_out,
    input  logic                 sq_error,
    input  logic                 sq_done
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nx;
    logic [IDW-1:0]  last;
    logic [IDW-1:0]  id_q;
    logic [IDW-1:0]  grant;
    logic            grant_vld;
    logic [15:0]     grant_data;
    logic [TW-1:0]   timer;
    logic            timer_expired;
    int              idx;

    // First valid requester searching upward from the one after the last served.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!grant_vld && req_valid[idx]) begin
                grant     = IDW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    assign grant_data    = req_data[16*int'(grant) +: 16];
    assign timer_expired = (timer == TW'(TIMEOUT - 1));

    // Gated by rst so every output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst && state == IDLE && grant_vld)
            req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (grant_vld) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (sq_done || timer_expired) state_nx = RESP;
            RESP:    if (rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last        <= IDW'(NREQ - 1);
            id_q        <= '0;
            sq_in       <= '0;
            timer       <= '0;
            rsp_root    <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        id_q  <= grant;
                        sq_in <= grant_data;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (sq_done) begin
                        rsp_root    <= sq_error ? 8'd0 : sq_out;
                        rsp_error   <= sq_error;
                        rsp_timeout <= 1'b0;
                    end else if (timer_expired) begin
                        rsp_root    <= 8'd0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                    end
                end
                RESP: if (rsp_ready) last <= id_q;
                default: ;
            endcase
        end
    end

    assign sq_start  = (state == ISSUE);
    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - randomized and directed bench for sqrt_arbiter against a behavioural model
module tb_sqrt_arbiter;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 32;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*16-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [7:0]          rsp_root;
    logic                rsp_error;
    logic                rsp_timeout;
    logic                sq_start;
    logic [15:0]         sq_in;
    logic [7:0]          sq_out;
    logic                sq_error;
    logic                sq_done;

    sqrt_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_root(rsp_root), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
        .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out),
        .sq_error(sq_error), .sq_done(sq_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Sqrt unit stand-in: done level is refreshed on the start edge; latency chosen per operation.
    bit          never_done = 1'b0;
    int          lat_max    = 12;
    int          done_at;
    logic        stub_busy;
    logic [15:0] stub_op;

    function automatic logic [7:0] stub_root(input logic [15:0] v);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return r[7:0];
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_busy <= 1'b0;
            stub_op   <= '0;
            done_at   <= 0;
        end else if (sq_start) begin
            stub_busy <= 1'b1;
            stub_op   <= sq_in;
            done_at   <= cyc + 1 + (sq_in[15] ? 0 : (never_done ? 100000 : int'($urandom_range(0, lat_max))));
        end
    end

    assign sq_done  = stub_busy && (cyc >= done_at);
    assign sq_error = sq_done ? stub_op[15] : 1'b0;
    assign sq_out   = sq_done ? stub_root(stub_op) : 8'hA5;

    // Reference model: rotating priority, one operation at a time, response timing from done/timeout rule.
    function automatic int rr_pick(input int last_id, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(last_id + k) % NREQ]) return (last_id + k) % NREQ;
        return -1;
    endfunction

    bit              busy_m, busy_pre, rsp_seen, exp_to;
    int              last_m, acc_id, acc_cyc, hs_cyc, acc_count, n_start, pick;
    logic [15:0]     acc_op;
    logic [NREQ-1:0] exp_rdy;
    logic [7:0]      exp_root;
    int              served_id[$];
    logic [9:0]      served_rsp[$];
    int              served_lat[$];

    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_sq_start", sq_start, 0);
            busy_m   = 1'b0;
            rsp_seen = 1'b0;
            last_m   = NREQ - 1;
        end else begin
            busy_pre = busy_m;
            exp_rdy  = '0;
            pick     = rr_pick(last_m, req_valid);
            if (!busy_pre && pick >= 0) exp_rdy[pick] = 1'b1;
            chk("req_ready", req_ready, exp_rdy);
            if (sq_start) begin
                n_start++;
                chk("start_cyc", cyc, busy_pre ? acc_cyc + 1 : -1);
                chk("sq_in", sq_in, acc_op);
            end
            if (!busy_pre) chk("rsp_idle", rsp_valid, 0);
            if (busy_pre && rsp_valid) begin
                if (!rsp_seen) begin
                    exp_to = (done_at > acc_cyc + 1 + TIMEOUT);
                    chk("rsp_lat", cyc - acc_cyc, exp_to ? 2 + TIMEOUT : done_at + 1 - acc_cyc);
                    served_lat.push_back(cyc - acc_cyc);
                    rsp_seen = 1'b1;
                end
                exp_root = (acc_op[15] || exp_to) ? 8'd0 : 8'(int'($floor($sqrt(real'(acc_op)))));
                chk("rsp_id", rsp_id, acc_id);
                chk("rsp_root", rsp_root, exp_root);
                chk("rsp_error", rsp_error, acc_op[15] | exp_to);
                chk("rsp_timeout", rsp_timeout, exp_to);
                if (rsp_ready) begin
                    served_id.push_back(int'(rsp_id));
                    served_rsp.push_back({rsp_timeout, rsp_error, rsp_root});
                    last_m   = acc_id;
                    busy_m   = 1'b0;
                    rsp_seen = 1'b0;
                    hs_cyc   = cyc;
                end
            end
            if (!busy_pre && (req_valid & req_ready) != 0 && pick >= 0) begin
                acc_id  = pick;
                acc_op  = req_data[16*pick +: 16];
                acc_cyc = cyc;
                busy_m  = 1'b1;
                acc_count++;
            end
        end
    end

    function automatic int sid(input int back);
        if (served_id.size() > back) return served_id[served_id.size() - 1 - back];
        return -1;
    endfunction

    function automatic logic [9:0] srsp(input int back);
        if (served_rsp.size() > back) return served_rsp[served_rsp.size() - 1 - back];
        return 10'h3FF;
    endfunction

    function automatic int slat();
        if (served_lat.size() > 0) return served_lat[served_lat.size() - 1];
        return -1;
    endfunction

    bit drop_on_hs = 1'b1;
    bit rand_mode  = 1'b0;

    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        if (drop_on_hs) req_valid = req_valid & ~hs;
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[16*i +: 16] = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h8000)
                                                                       : 16'($urandom_range(0, 16'h7FFF));
                end
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic wait_served(input string tag, input int n, input int max_cycles);
        int target = served_id.size() + n;
        for (int k = 0; k < max_cycles && served_id.size() < target; k++) step();
        chk(tag, served_id.size() >= target, 1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) step();
        rst = 1'b1;
    endtask

    initial begin
        int s0, a0;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_id", rsp_id, 0);
        chk("reset_rsp_root", rsp_root, 0);
        chk("reset_rsp_flags", {rsp_error, rsp_timeout}, 0);
        chk("reset_sq_in", sq_in, 0);
        rst = 1'b1;

        // Single request from id 2, operand 144.
        s0 = n_start;
        req_data[2*16 +: 16] = 16'd144;
        req_valid[2] = 1'b1;
        wait_served("t1_wait", 1, 40);
        chk("t1_id", sid(0), 2);
        chk("t1_rsp", srsp(0), {1'b0, 1'b0, 8'd12});
        chk("t1_starts", n_start - s0, 1);

        // Negative operand: response three cycles after accept.
        req_data[0*16 +: 16] = 16'h8001;
        req_valid[0] = 1'b1;
        wait_served("t2_wait", 1, 20);
        chk("t2_id", sid(0), 0);
        chk("t2_rsp", srsp(0), {1'b0, 1'b1, 8'd0});
        chk("t2_lat", slat(), 3);

        // All requesters valid from reset: rotating service order.
        do_reset();
        drop_on_hs = 1'b0;
        req_data   = {16'd9, 16'd4, 16'd1, 16'd0};
        req_valid  = 4'hF;
        wait_served("t3_wait", 5, 150);
        req_valid  = '0;
        drop_on_hs = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("t3_order", sid(4 - k), k % 4);
            chk("t3_root", srsp(4 - k), {2'b00, 8'(k % 4)});
        end

        // sqrt unit never completes: forced timeout.
        never_done = 1'b1;
        req_data[1*16 +: 16] = 16'd100;
        req_valid[1] = 1'b1;
        wait_served("t4_wait", 1, 60);
        never_done = 1'b0;
        chk("t4_id", sid(0), 1);
        chk("t4_rsp", srsp(0), {1'b1, 1'b1, 8'd0});
        chk("t4_lat", slat(), 34);

        // Backpressure on the response with another request pending.
        rsp_ready = 1'b0;
        req_data[1*16 +: 16] = 16'd25;
        req_data[3*16 +: 16] = 16'd49;
        req_valid[1] = 1'b1;
        req_valid[3] = 1'b1;
        for (int k = 0; k < 40 && !rsp_valid; k++) step();
        chk("t5_rsp_valid", rsp_valid, 1);
        s0 = n_start;
        repeat (20) step();
        chk("t5_no_start", n_start - s0, 0);
        chk("t5_held_valid", rsp_valid, 1);
        a0 = acc_count;
        rsp_ready = 1'b1;
        for (int k = 0; k < 10 && acc_count == a0; k++) step();
        chk("t5_gap", acc_cyc - hs_cyc, 1);
        wait_served("t5_wait", 1, 40);
        chk("t5_first", sid(1), 3);
        chk("t5_second", sid(0), 1);
        chk("t5_rsp", srsp(0), {2'b00, 8'd5});

        // Reset during WAIT aborts the operation; requester 0 wins afterwards.
        never_done = 1'b1;
        req_data[2*16 +: 16] = 16'd400;
        req_valid[2] = 1'b1;
        a0 = acc_count;
        for (int k = 0; k < 10 && acc_count == a0; k++) step();
        step();
        req_data  = {16'd64, 16'd49, 16'd36, 16'd81};
        req_valid = 4'hF;
        rst = 1'b0;
        #1;
        chk("t6_rst_outputs", {req_ready, rsp_valid, sq_start, rsp_error, rsp_timeout}, 0);
        chk("t6_rst_data", {sq_in, rsp_root, 6'd0, rsp_id}, 0);
        repeat (2) step();
        never_done = 1'b0;
        rst = 1'b1;
        wait_served("t6_wait", 1, 40);
        chk("t6_first_id", sid(0), 0);
        chk("t6_rsp", srsp(0), {2'b00, 8'd9});

        // Randomized traffic with random backpressure and latencies straddling the timeout.
        lat_max   = 40;
        rand_mode = 1'b1;
        repeat (4000) step();
        rand_mode = 1'b0;
        rsp_ready = 1'b1;
        repeat (300) step();
        chk("drain_idle", busy_m, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
